alu_muldiv: RTL
===============

# alu_muldiv

Parametrised iterative multiply/divide unit implementing the RV M-extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for an XLEN-wide datapath. It sits beside the single-cycle ALU in the execute stage and shares the operand buses with it. Multi-cycle radix-2 shift-add and restoring-division engines are paced by a start/busy/done handshake. Divide-by-zero and signed-overflow cases take a 1-cycle fast path.

## Interface
- XLEN, 32, operand/result width (≥ 4); iteration counter is $clog2(XLEN+1) bits
- i_clk  in  1  clock, rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_start  in  1  request; accepted only when o_busy=0 and i_kill=0
- i_kill  in  1  abort in-flight operation (pipeline flush)
- i_md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_op_a  in  XLEN  rs1 / multiplicand / dividend
- i_op_b  in  XLEN  rs2 / multiplier / divisor
- o_busy  out  1  operation in flight; requests ignored
- o_done  out  1  one-cycle pulse, o_md_data valid
- o_md_data  out  XLEN  result, held until next o_done

## Operation
- States: IDLE, CALC, FIN. Reset → IDLE; o_busy=0, o_done=0, o_md_data=0, all internal registers 0.
- Accept (IDLE, i_start=1, i_kill=0, edge E0): latch op, operand signs, absolute values of operands; clear counter and accumulator. Operands may change after E0.
- Signedness: a is signed for MULH, MULHSU, DIV, REM; b is signed for MULH, DIV, REM. MUL is sign-agnostic (low half); it is computed as signed-signed.
- Fast path, checked at E0, DIV/DIVU/REM/REMU only:
  - b=0: quotient all ones; remainder = i_op_a.
  - Signed only, a=100…0 and b=all ones: quotient = a; remainder 0.
  - Result loaded at E0; next state IDLE; o_done=1 the following cycle.
- CALC: one iteration per edge on unsigned magnitudes, XLEN iterations.
  - MUL: 2·XLEN accumulator shift-add, LSB-first multiplier.
  - DIV: restoring; shift remainder left, subtract divisor, set quotient bit if non-negative.
  - After XLEN iterations → FIN.
- FIN, one edge: apply sign correction.
  - Product negated if sa^sb.
  - Quotient negated if sa^sb.
  - Remainder negated if sa.
  - Select the low XLEN bits (MUL), the high XLEN bits (MULH*), the quotient, or the remainder; load o_md_data; → IDLE; o_done=1 next cycle.
- Width rules: all negation is two's complement mod 2^XLEN (2^(2·XLEN) for products). Magnitude of the most-negative value is 2^(XLEN-1), held in XLEN unsigned bits.
- i_kill in CALC or FIN: next edge → IDLE; o_busy=0; no o_done; o_md_data unchanged.
- i_kill and i_start together in IDLE: request dropped.
- i_start while o_busy=1: ignored, not queued.
- Asynchronous reset at any time, including mid-CALC: immediate return to reset values; no o_done.

## Timing
- Normal latency: E0 accept; o_done high in the cycle after edge E0+XLEN+1 (XLEN+1 cycles). For XLEN=32, o_done is 33 cycles after accept.
- Fast-path latency: o_done high 1 cycle after accept; o_busy never asserts.
- o_busy: 1 from after E0 until the edge that asserts o_done. It is 0 during the o_done cycle, so back-to-back starts are accepted in the done cycle.
- o_done: exactly one cycle per completed operation.
- o_md_data: changes only on the edge that raises o_done, or on reset.

## Test plan
- MUL: 7 × 0xFFFFFFFD (−3), XLEN=32 → o_md_data=0xFFFFFFEB; o_done exactly 33 cycles after accept; o_busy high 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MULHU on the same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU → 0x7FFFFFFC; REMU → 1.
- Fast path:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - Each o_done is 1 cycle after accept with o_busy=0.
- Flow control:
  - i_start pulsed while busy → ignored; single o_done.
  - i_kill at cycle 10 of a DIV → no o_done; o_md_data keeps the previous result.
  - New start in the o_done cycle → accepted; second result correct.
- Reset and width:
  - i_reset asserted mid-CALC → o_busy, o_done, o_md_data = 0 immediately.
  - After release, MUL 3×4 → 12.
  - XLEN=8 build, exhaustive all ops × all operand pairs vs reference model.

Source files
------------

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M/RV64M-style multiply/divide unit.
//   Radix-2 shift-add multiplier and restoring divider, one iteration per
//   clock, on operand magnitudes; sign fix-up is applied in a final cycle.
//   Divide-by-zero and signed overflow (MIN / -1) complete on the accept edge.
// Ports:
//   i_clk, i_reset      clock (rising edge), async active-high reset
//   i_start, i_kill     request (IDLE only) / abort of an in-flight operation
//   i_md_op[2:0]        funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   i_op_a, i_op_b      rs1 / rs2
//   o_busy              operation in flight, requests ignored
//   o_done              one-cycle pulse, o_md_data valid
//   o_md_data           result, held until the next o_done
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [2:0]      i_md_op,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_md_data
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [2:0]        op;
    logic              sa, sb;
    logic [XLEN-1:0]   opnd;   // multiplicand (MUL*) or divisor (DIV*)
    logic [2*XLEN-1:0] acc;    // {hi, lo}: product / {remainder, quotient}
    logic [CW-1:0]     cnt;
    logic              done;

    // ---------------- accept-edge decode ----------------
    logic            is_div, a_signed, b_signed, neg_a, neg_b;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b, fast_res;

    always_comb begin
        is_div   = i_md_op[2];
        // MUL (low half) is sign-agnostic; treat it as signed x signed
        a_signed = (i_md_op == 3'd0) || (i_md_op == 3'd1) || (i_md_op == 3'd2) ||
                   (i_md_op == 3'd4) || (i_md_op == 3'd6);
        b_signed = (i_md_op == 3'd0) || (i_md_op == 3'd1) ||
                   (i_md_op == 3'd4) || (i_md_op == 3'd6);
        neg_a    = a_signed & i_op_a[XLEN-1];
        neg_b    = b_signed & i_op_b[XLEN-1];
        // -MIN wraps back to MIN, which as unsigned is exactly 2^(XLEN-1)
        abs_a    = neg_a ? -i_op_a : i_op_a;
        abs_b    = neg_b ? -i_op_b : i_op_b;
        div_zero = is_div && (i_op_b == '0);
        div_ovf  = is_div && !i_md_op[0] && (i_op_a == MIN_VAL) && (i_op_b == '1);
        // i_md_op[1] selects the remainder flavour among the divides
        if (div_zero) fast_res = i_md_op[1] ? i_op_a : '1;
        else          fast_res = i_md_op[1] ? '0     : i_op_a;
    end

    // ---------------- one iteration ----------------
    logic [XLEN:0]     mul_sum, trial;
    logic              ge;
    logic [2*XLEN-1:0] mul_next, div_next;

    always_comb begin
        // shift-add: the multiplier sits in acc[XLEN-1:0] and is consumed LSB first
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[XLEN-1:1]};
        // restoring divide: shifted remainder can reach XLEN+1 bits
        trial    = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        ge       = !trial[XLEN];
        div_next = {(ge ? trial[XLEN-1:0] : acc[2*XLEN-2:XLEN-1]), acc[XLEN-2:0], ge};
    end

    // ---------------- sign fix-up and select ----------------
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fin_res;

    always_comb begin
        prod = (sa ^ sb) ? -acc : acc;
        quo  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            3'd0:                fin_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fin_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fin_res = quo;
            default:             fin_res = rem;
        endcase
    end

    // ---------------- control ----------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= S_IDLE;
            op        <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            opnd      <= '0;
            acc       <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            o_md_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && !i_kill) begin
                        op  <= i_md_op;
                        sa  <= neg_a;
                        sb  <= neg_b;
                        cnt <= '0;
                        if (div_zero || div_ovf) begin
                            o_md_data <= fast_res;
                            done      <= 1'b1;
                        end else begin
                            state <= S_CALC;
                            opnd  <= is_div ? abs_b : abs_a;
                            acc   <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
                        end
                    end
                end
                S_CALC: begin
                    if (i_kill) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= op[2] ? div_next : mul_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(XLEN - 1)) state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    if (!i_kill) begin
                        o_md_data <= fin_res;
                        done      <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (state != S_IDLE);
    assign o_done = done;

endmodule
